// File: rtl/dcnt_seq_if.sv
// Handshake bundle for dcnt_seq: start/load command in, valid/ready sequence out.
// The slave side is the sequencer; the master side is the controller plus downstream consumer.
interface dcnt_seq_if #(
  parameter int SIZE_ = 8
);
  logic             start_;
  logic [SIZE_-1:0] n_;
  logic             rdy_;
  logic [SIZE_-1:0] q_;
  logic             vld_;
  logic             last_;
  logic             busy_;
  logic             done_;

  modport master (
    output start_, n_, rdy_,
    input  q_, vld_, last_, busy_, done_
  );

  modport slave (
    input  start_, n_, rdy_,
    output q_, vld_, last_, busy_, done_
  );
endinterface

// File: rtl/dcnt_seq.sv
// Loadable down-counter sequencer: streams n..T one beat per cycle, first beat 1 cycle after start_;
// rdy_ low freezes the current beat. DCNT_SKIP_ONE_EN raises the terminal value T from 1 to 2.
module dcnt_seq #(
  parameter int SIZE_ = 8
) (
  input  logic       clk_,
  input  logic       rst_,
  dcnt_seq_if.slave  bus_
);

`ifdef DCNT_SKIP_ONE_EN
  localparam logic [SIZE_-1:0] TERM = SIZE_'(2);
`else
  localparam logic [SIZE_-1:0] TERM = SIZE_'(1);
`endif
  localparam logic [SIZE_-1:0] ONE = SIZE_'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SIZE_-1:0] q_r;
  logic [SIZE_-1:0] q_nxt;
  logic             vld_r;
  logic             vld_nxt;
  logic             last;

  // q_ <= TERM also covers the n_<=1 single beat when the skip option raises TERM to 2.
  assign last = vld_r && (q_r <= TERM);

  always_ff @(posedge clk_) begin
    if (rst_) begin
      state <= IDLE;
      q_r   <= '0;
      vld_r <= 1'b0;
    end else begin
      state <= state_nxt;
      q_r   <= q_nxt;
      vld_r <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    vld_nxt   = vld_r;
    case (state)
      IDLE: begin
        if (bus_.start_) begin
          // n_=0 and (with skip) n_=1 both collapse to the single beat q_=1.
          q_nxt     = (bus_.n_ == '0) ? ONE : bus_.n_;
          vld_nxt   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (vld_r && bus_.rdy_) begin
          if (last) begin
            vld_nxt   = 1'b0;
            state_nxt = DONE;
          end else begin
            q_nxt = q_r - ONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus_.q_    = q_r;
  assign bus_.vld_  = vld_r;
  assign bus_.last_ = last;
  assign bus_.busy_ = (state != IDLE);
  assign bus_.done_ = (state == DONE);

endmodule

// File: tb/tb_dcnt_seq.sv
// Directed bench for dcnt_seq: each task drives one scenario and checks it inline.
module tb_dcnt_seq;

`ifdef DCNT_SKIP_ONE_EN
  localparam int TERM = 2;
`else
  localparam int TERM = 1;
`endif

  logic clk_ = 1'b0;
  logic rst_ = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dcnt_seq_if #(.SIZE_(8)) bus_ ();

  dcnt_seq #(.SIZE_(8)) dut (
    .clk_ (clk_),
    .rst_ (rst_),
    .bus_ (bus_)
  );

  always #5 clk_ = ~clk_;

  task automatic step();
    @(posedge clk_);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b1; bus_.start_ = 1'b0; bus_.n_ = 8'd0; bus_.rdy_ = 1'b0;
    step(); step();
    checks++; if (bus_.q_ !== 8'd0)    begin errors++; $display("FAIL reset_q got=%0d exp=0", bus_.q_); end
    checks++; if (bus_.vld_ !== 1'b0)  begin errors++; $display("FAIL reset_vld got=%b exp=0", bus_.vld_); end
    checks++; if (bus_.last_ !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", bus_.last_); end
    checks++; if (bus_.busy_ !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_.busy_); end
    checks++; if (bus_.done_ !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus_.done_); end
    rst_ = 1'b0;
    step();
  endtask

  task automatic test_basic_seq();
    bus_.start_ = 1'b1; bus_.n_ = 8'd5; bus_.rdy_ = 1'b1;
    step();
    bus_.start_ = 1'b0; bus_.n_ = 8'd7;
    for (int e = 5; e >= TERM; e--) begin
      checks++; if (bus_.q_ !== 8'(e) || bus_.vld_ !== 1'b1)
        begin errors++; $display("FAIL basic_beat got q=%0d vld=%b exp q=%0d vld=1", bus_.q_, bus_.vld_, e); end
      checks++; if (bus_.last_ !== (e == TERM))
        begin errors++; $display("FAIL basic_last at q=%0d got=%b exp=%b", e, bus_.last_, (e == TERM)); end
      checks++; if (bus_.done_ !== 1'b0 || bus_.busy_ !== 1'b1)
        begin errors++; $display("FAIL basic_run_flags got done=%b busy=%b exp done=0 busy=1", bus_.done_, bus_.busy_); end
      step();
    end
    checks++; if (bus_.done_ !== 1'b1 || bus_.vld_ !== 1'b0 || bus_.busy_ !== 1'b1)
      begin errors++; $display("FAIL basic_done got done=%b vld=%b busy=%b exp 1 0 1", bus_.done_, bus_.vld_, bus_.busy_); end
    checks++; if (bus_.q_ !== 8'(TERM))
      begin errors++; $display("FAIL basic_hold_q got=%0d exp=%0d", bus_.q_, TERM); end
    step();
    checks++; if (bus_.done_ !== 1'b0 || bus_.busy_ !== 1'b0 || bus_.q_ !== 8'(TERM))
      begin errors++; $display("FAIL basic_idle got done=%b busy=%b q=%0d exp 0 0 %0d", bus_.done_, bus_.busy_, bus_.q_, TERM); end
  endtask

  task automatic test_stall();
    int got[$];
    bit seen_done = 1'b0;
    bus_.start_ = 1'b1; bus_.n_ = 8'd3; bus_.rdy_ = 1'b1;
    step();
    bus_.start_ = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      bus_.rdy_ = !(c >= 1 && c <= 3);
      if (c >= 1 && c <= 4) begin
        checks++; if (bus_.q_ !== 8'd2 || bus_.vld_ !== 1'b1)
          begin errors++; $display("FAIL stall_hold c=%0d got q=%0d vld=%b exp q=2 vld=1", c, bus_.q_, bus_.vld_); end
      end
      if (bus_.done_) seen_done = 1'b1;
      else begin
        if (bus_.vld_ && bus_.rdy_) got.push_back(int'(bus_.q_));
        step();
      end
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL stall_timeout got done=0 exp done=1"); end
    checks++; if (got.size() !== 3 - TERM + 1)
      begin errors++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), 3 - TERM + 1); end
    for (int i = 0; i < got.size() && i < 3 - TERM + 1; i++) begin
      checks++; if (got[i] !== 3 - i) begin errors++; $display("FAIL stall_beat%0d got=%0d exp=%0d", i, got[i], 3 - i); end
    end
    step();
  endtask

  task automatic test_zero_one();
    for (int k = 0; k < 2; k++) begin
      bus_.start_ = 1'b1; bus_.n_ = 8'(k); bus_.rdy_ = 1'b1;
      step();
      bus_.start_ = 1'b0;
      checks++; if (bus_.q_ !== 8'd1 || bus_.vld_ !== 1'b1 || bus_.last_ !== 1'b1)
        begin errors++; $display("FAIL single_beat n=%0d got q=%0d vld=%b last=%b exp 1 1 1", k, bus_.q_, bus_.vld_, bus_.last_); end
      step();
      checks++; if (bus_.done_ !== 1'b1 || bus_.vld_ !== 1'b0)
        begin errors++; $display("FAIL single_done n=%0d got done=%b vld=%b exp 1 0", k, bus_.done_, bus_.vld_); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int got[$];
    int beats = 0;
    bit seen_done = 1'b0;
    bus_.start_ = 1'b1; bus_.n_ = 8'd4; bus_.rdy_ = 1'b1;
    step();
    for (int c = 0; c < 20 && !seen_done; c++) begin
      bus_.start_ = (c == 1);
      bus_.n_ = (c == 1) ? 8'd9 : 8'd4;
      if (bus_.done_) seen_done = 1'b1;
      else begin
        if (bus_.vld_) got.push_back(int'(bus_.q_));
        step();
      end
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL ignore_timeout got done=0 exp done=1"); end
    checks++; if (got.size() !== 4 - TERM + 1)
      begin errors++; $display("FAIL ignore_count got=%0d exp=%0d", got.size(), 4 - TERM + 1); end
    for (int i = 0; i < got.size() && i < 4 - TERM + 1; i++) begin
      checks++; if (got[i] !== 4 - i) begin errors++; $display("FAIL ignore_beat%0d got=%0d exp=%0d", i, got[i], 4 - i); end
    end
    // start_ held from the done_ cycle: ignored in DONE, taken in the following IDLE cycle.
    bus_.start_ = 1'b1; bus_.n_ = 8'd9;
    step();
    checks++; if (bus_.vld_ !== 1'b0 || bus_.busy_ !== 1'b0 || bus_.q_ !== 8'(TERM))
      begin errors++; $display("FAIL b2b_done_ignore got vld=%b busy=%b q=%0d exp 0 0 %0d", bus_.vld_, bus_.busy_, bus_.q_, TERM); end
    step();
    bus_.start_ = 1'b0;
    checks++; if (bus_.vld_ !== 1'b1 || bus_.q_ !== 8'd9)
      begin errors++; $display("FAIL b2b_load got vld=%b q=%0d exp 1 9", bus_.vld_, bus_.q_); end
    seen_done = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (bus_.done_) seen_done = 1'b1;
      else begin
        if (bus_.vld_) beats++;
        step();
      end
    end
    checks++; if (!seen_done || beats !== 9 - TERM + 1)
      begin errors++; $display("FAIL b2b_drain got done=%b beats=%0d exp done=1 beats=%0d", seen_done, beats, 9 - TERM + 1); end
    step();
  endtask

  task automatic test_reset_mid_run();
    bus_.start_ = 1'b1; bus_.n_ = 8'd5; bus_.rdy_ = 1'b1;
    step();
    bus_.start_ = 1'b0;
    step(); step(); step();
    checks++; if (bus_.q_ !== 8'd2 || bus_.vld_ !== 1'b1)
      begin errors++; $display("FAIL midrst_pre got q=%0d vld=%b exp q=2 vld=1", bus_.q_, bus_.vld_); end
    rst_ = 1'b1;
    step();
    checks++; if (bus_.q_ !== 8'd0 || bus_.vld_ !== 1'b0 || bus_.last_ !== 1'b0 || bus_.busy_ !== 1'b0 || bus_.done_ !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got q=%0d vld=%b last=%b busy=%b done=%b exp all 0",
                               bus_.q_, bus_.vld_, bus_.last_, bus_.busy_, bus_.done_); end
    rst_ = 1'b0;
    step();
    checks++; if (bus_.done_ !== 1'b0 || bus_.busy_ !== 1'b0 || bus_.vld_ !== 1'b0)
      begin errors++; $display("FAIL midrst_after got done=%b busy=%b vld=%b exp 0 0 0", bus_.done_, bus_.busy_, bus_.vld_); end
  endtask

  task automatic test_max();
    int beats = 0;
    int lasts = 0;
    int last_q = -1;
    bit seen_done = 1'b0;
    bus_.start_ = 1'b1; bus_.n_ = 8'd255; bus_.rdy_ = 1'b1;
    step();
    bus_.start_ = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      if (bus_.done_) seen_done = 1'b1;
      else begin
        if (bus_.vld_) begin
          beats++;
          if (bus_.last_) begin lasts++; last_q = int'(bus_.q_); end
        end
        step();
      end
    end
    checks++; if (!seen_done || beats !== 255 - TERM + 1)
      begin errors++; $display("FAIL max_beats got done=%b beats=%0d exp done=1 beats=%0d", seen_done, beats, 255 - TERM + 1); end
    checks++; if (lasts !== 1 || last_q !== TERM)
      begin errors++; $display("FAIL max_last got count=%0d q=%0d exp count=1 q=%0d", lasts, last_q, TERM); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_seq();
    test_stall();
    test_zero_one();
    test_back_to_back();
    test_reset_mid_run();
    test_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
